// File: rtl/cpu_bus_responder.sv
// CPU-side memory responder: mirrored 2 KB RAM, PRG ROM window, open bus and a transaction log.
// Read data appears 1 clk after the phi2 rise. Writes commit on the phi2 fall. The log drops entries when full.
module cpu_bus_responder #(
    parameter int         ROM_AW        = 15,
    parameter int         FIFO_DEPTH    = 16,
    parameter logic [7:0] OPEN_BUS_INIT = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              syn_clk,
    input  logic              ren,
    input  logic              wen,
    input  logic [15:0]       cpu_addr_out,
    input  logic [7:0]        cpu_data_out,
    output logic [7:0]        cpu_data_in,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_rom,
    input  logic [ROM_AW-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              txn_valid,
    input  logic              txn_ready,
    output logic [15:0]       txn_addr,
    output logic [7:0]        txn_data,
    output logic              txn_write,
    output logic              txn_overflow
);
    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

    logic          syn_q;
    logic          rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    data_in_q, data_in_d, obus_q, obus_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]   cnt_q, cnt_d;

    logic [7:0]  ram_mem  [2048];
    logic [7:0]  rom_mem  [2**ROM_AW];
    logic [24:0] fifo_mem [FIFO_DEPTH];

    logic        rise, fall, wr_commit, ld_fire, is_ram, is_rom;
    logic [7:0]  rd_val;
    logic        ram_we;
    logic [10:0] ram_widx;
    logic [7:0]  ram_wdat;
    logic        push, push_ok, pop, full;
    logic [24:0] push_dat, head;

    assign rise      = syn_clk & ~syn_q;
    assign fall      = ~syn_clk & syn_q;
    assign wr_commit = fall & wr_pend_q;
    // A CPU write commit owns the RAM write port, so the backdoor waits that clk.
    assign ld_ready  = ~wr_commit;
    assign ld_fire   = ld_valid & ld_ready;
    assign is_ram    = addr_q < 16'h2000;
    assign is_rom    = addr_q[15];

    always_comb begin
        if (is_ram)      rd_val = ram_mem[addr_q[10:0]];
        else if (is_rom) rd_val = rom_mem[addr_q[ROM_AW-1:0]];
        else             rd_val = obus_q;
    end

    always_comb begin
        rd_pend_d = rise & ren;
        wr_pend_d = wr_pend_q;
        addr_d    = addr_q;
        data_in_d = data_in_q;
        obus_d    = obus_q;
        push      = 1'b0;
        push_dat  = '0;
        ram_we    = 1'b0;
        ram_widx  = '0;
        ram_wdat  = '0;
        if (rise && (ren || wen)) addr_d = cpu_addr_out;
        if (rise && wen)          wr_pend_d = 1'b1;
        else if (wr_commit)       wr_pend_d = 1'b0;
        if (rd_pend_q) begin
            data_in_d = rd_val;
            obus_d    = rd_val;
            push      = 1'b1;
            push_dat  = {addr_q, rd_val, 1'b0};
        end
        if (wr_commit) begin
            obus_d   = cpu_data_out;
            push     = 1'b1;
            push_dat = {addr_q, cpu_data_out, 1'b1};
        end
        if (wr_commit && is_ram) begin
            ram_we   = 1'b1;
            ram_widx = addr_q[10:0];
            ram_wdat = cpu_data_out;
        end else if (ld_fire && !ld_rom) begin
            ram_we   = 1'b1;
            ram_widx = ld_addr[10:0];
            ram_wdat = ld_data;
        end
    end

    // Pop frees a slot before the push is judged, so push+pop at full never drops.
    always_comb begin
        full    = cnt_q == DEPTH_C;
        pop     = txn_valid & txn_ready;
        push_ok = push & (~full | pop);
        ovf_d   = ovf_q | (push & ~push_ok);
        wptr_d  = wptr_q + PW'(push_ok);
        rptr_d  = rptr_q + PW'(pop);
        cnt_d   = cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syn_q     <= 1'b1;
            rd_pend_q <= 1'b0;
            wr_pend_q <= 1'b0;
            addr_q    <= '0;
            data_in_q <= 8'h00;
            obus_q    <= OPEN_BUS_INIT;
            ovf_q     <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            syn_q     <= syn_clk;
            rd_pend_q <= rd_pend_d;
            wr_pend_q <= wr_pend_d;
            addr_q    <= addr_d;
            data_in_q <= data_in_d;
            obus_q    <= obus_d;
            ovf_q     <= ovf_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we)            ram_mem[ram_widx]  <= ram_wdat;
        if (ld_fire && ld_rom) rom_mem[ld_addr]   <= ld_data;
        if (push_ok)           fifo_mem[wptr_q]   <= push_dat;
    end

    assign head         = fifo_mem[rptr_q];
    assign txn_valid    = cnt_q != '0;
    assign txn_addr     = txn_valid ? head[24:9] : 16'h0000;
    assign txn_data     = txn_valid ? head[8:1]  : 8'h00;
    assign txn_write    = txn_valid & head[0];
    assign txn_overflow = ovf_q;
    assign cpu_data_in  = data_in_q;
endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: reset, fetch, mirroring, open bus, log overflow, backdoor arbitration, mid-cycle reset.
module tb_cpu_bus_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        syn_clk = 1'b0, ren = 1'b0, wen = 1'b0;
    logic [15:0] cpu_addr_out = '0;
    logic [7:0]  cpu_data_out = '0;
    logic [7:0]  cpu_data_in;
    logic        ld_valid = 1'b0, ld_ready, ld_rom = 1'b0;
    logic [14:0] ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic        txn_valid, txn_ready = 1'b0;
    logic [15:0] txn_addr;
    logic [7:0]  txn_data;
    logic        txn_write, txn_overflow;

    int n_chk = 0;
    int n_bad = 0;

    cpu_bus_responder #(.ROM_AW(15), .FIFO_DEPTH(16), .OPEN_BUS_INIT(8'h00)) dut (
        .clk(clk), .rst(rst), .syn_clk(syn_clk), .ren(ren), .wen(wen),
        .cpu_addr_out(cpu_addr_out), .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rom(ld_rom), .ld_addr(ld_addr), .ld_data(ld_data),
        .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_addr(txn_addr), .txn_data(txn_data),
        .txn_write(txn_write), .txn_overflow(txn_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic rom, input logic [14:0] a, input logic [7:0] d);
        ld_valid = 1'b1; ld_rom = rom; ld_addr = a; ld_data = d;
        tick;
        ld_valid = 1'b0;
    endtask

    // Rise edge latches the address; data must still hold its old value until the next clk.
    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        logic [7:0] prev;
        prev = cpu_data_in;
        syn_clk = 1'b1; ren = 1'b1; cpu_addr_out = a;
        tick;
        chk("rd_latency", cpu_data_in, prev);
        tick;
        d = cpu_data_in;
        syn_clk = 1'b0; ren = 1'b0;
        tick;
        tick;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        syn_clk = 1'b1; wen = 1'b1; cpu_addr_out = a; cpu_data_out = d;
        tick;
        tick;
        syn_clk = 1'b0;
        tick;
        wen = 1'b0;
        tick;
    endtask

    task automatic pop_chk(input string tag, input logic [15:0] a, input logic [7:0] d,
                           input logic w, input logic chk_d);
        chk({tag, "_vld"}, txn_valid, 1'b1);
        chk({tag, "_addr"}, txn_addr, a);
        if (chk_d) chk({tag, "_data"}, txn_data, d);
        chk({tag, "_wr"}, txn_write, w);
        txn_ready = 1'b1;
        tick;
        txn_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        tick;
        chk("rst_data_in", cpu_data_in, 8'h00);
        chk("rst_txn_valid", txn_valid, 1'b0);
        chk("rst_ovf", txn_overflow, 1'b0);
        chk("rst_txn_addr", txn_addr, 16'h0000);
        chk("rst_txn_data", txn_data, 8'h00);
        chk("rst_txn_write", txn_write, 1'b0);
        chk("rst_ld_ready", ld_ready, 1'b1);
        load(1'b1, 15'h7FFC, 8'h00);
        load(1'b1, 15'h7FFD, 8'h80);
        load(1'b1, 15'h0000, 8'hEA);
        load(1'b0, 15'h0001, 8'h00);
        rst = 1'b0;
        tick;

        // Reset vector fetch
        cpu_read(16'hFFFC, rd); chk("rv_lo", rd, 8'h00);
        cpu_read(16'hFFFD, rd); chk("rv_hi", rd, 8'h80);
        pop_chk("t_fffc", 16'hFFFC, 8'h00, 1'b0, 1'b1);
        pop_chk("t_fffd", 16'hFFFD, 8'h80, 1'b0, 1'b1);
        chk("empty1", txn_valid, 1'b0);

        // RAM mirroring
        cpu_write(16'h0012, 8'h5A);
        cpu_read(16'h0812, rd); chk("mir_0812", rd, 8'h5A);
        cpu_read(16'h1012, rd); chk("mir_1012", rd, 8'h5A);
        cpu_read(16'h1812, rd); chk("mir_1812", rd, 8'h5A);
        pop_chk("t_w12", 16'h0012, 8'h5A, 1'b1, 1'b1);
        pop_chk("t_r0812", 16'h0812, 8'h5A, 1'b0, 1'b1);
        pop_chk("t_r1012", 16'h1012, 8'h5A, 1'b0, 1'b1);
        pop_chk("t_r1812", 16'h1812, 8'h5A, 1'b0, 1'b1);

        // ROM write ignored, open bus follows last bus value
        cpu_write(16'h8000, 8'h33);
        cpu_read(16'h4020, rd); chk("obus_wr", rd, 8'h33);
        cpu_read(16'h8000, rd); chk("rom_8000", rd, 8'hEA);
        cpu_read(16'h4020, rd); chk("obus_rd", rd, 8'hEA);
        pop_chk("t_w8000", 16'h8000, 8'h33, 1'b1, 1'b1);
        pop_chk("t_r4020a", 16'h4020, 8'h33, 1'b0, 1'b1);
        pop_chk("t_r8000", 16'h8000, 8'hEA, 1'b0, 1'b1);
        pop_chk("t_r4020b", 16'h4020, 8'hEA, 1'b0, 1'b1);
        chk("empty2", txn_valid, 1'b0);

        // Log overflow: 17 reads into a 16-deep log
        for (int i = 0; i < 17; i++) begin
            cpu_read(16'h0100 + 16'(i), rd);
            if (i == 15) chk("ovf_at16", txn_overflow, 1'b0);
        end
        chk("ovf_vld", txn_valid, 1'b1);
        chk("ovf_set", txn_overflow, 1'b1);
        for (int i = 0; i < 16; i++) pop_chk("drain", 16'h0100 + 16'(i), 8'h00, 1'b0, 1'b0);
        chk("drain_empty", txn_valid, 1'b0);

        // Backdoor load collides with a CPU write commit
        syn_clk = 1'b1; wen = 1'b1; cpu_addr_out = 16'h0005; cpu_data_out = 8'h11;
        tick;
        tick;
        syn_clk = 1'b0;
        ld_valid = 1'b1; ld_rom = 1'b0; ld_addr = 15'h0005; ld_data = 8'h22;
        #1;
        chk("ld_blocked", ld_ready, 1'b0);
        tick;
        chk("ld_ready_after", ld_ready, 1'b1);
        wen = 1'b0;
        tick;
        ld_valid = 1'b0;
        cpu_read(16'h0005, rd); chk("ld_wins", rd, 8'h22);
        pop_chk("t_w0005", 16'h0005, 8'h11, 1'b1, 1'b1);

        // Reset in the middle of a write cycle
        syn_clk = 1'b1; wen = 1'b1; cpu_addr_out = 16'h0001; cpu_data_out = 8'h77;
        tick;
        rst = 1'b1;
        #1;
        chk("mrst_data_in", cpu_data_in, 8'h00);
        chk("mrst_txn_valid", txn_valid, 1'b0);
        chk("mrst_ovf", txn_overflow, 1'b0);
        chk("mrst_txn_addr", txn_addr, 16'h0000);
        syn_clk = 1'b0; wen = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        chk("mrst_no_commit", txn_valid, 1'b0);
        cpu_read(16'h0001, rd); chk("mrst_ram", rd, 8'h00);
        pop_chk("t_r0001", 16'h0001, 8'h00, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Memory-side responder directly downstream of the CPU DUV wrapper.
- Consumes the wrapper's phi2 strobe (syn_clk), ren/wen, address and write data; returns read data on cpu_data_in.
- Models 2 KB mirrored work RAM and a PRG ROM window, with a backdoor loader for the bench.
- Pushes every completed bus cycle into a transaction FIFO for the scoreboard.

Parameters:
- ROM_AW, 15, PRG ROM address width; ROM spans $8000-$FFFF and is mirrored when ROM_AW < 15.
- FIFO_DEPTH, 16, transaction log depth; must be a power of 2 and at least 2.
- OPEN_BUS_INIT, 8'h00, open-bus latch value after reset.

Ports:
- clk  in  1  system clock; same clock as the CPU wrapper; syn_clk is sampled on it.
- rst  in  1  asynchronous reset, active-high.
- syn_clk  in  1  phi2 from the CPU wrapper.
- ren  in  1  CPU read cycle.
- wen  in  1  CPU write cycle; ren and wen are mutually exclusive.
- cpu_addr_out  in  16  CPU address.
- cpu_data_out  in  8  CPU write data.
- cpu_data_in  out  8  read data to the CPU.
- ld_valid  in  1  backdoor load request.
- ld_ready  out  1  backdoor load accepted this cycle.
- ld_rom  in  1  1 = load ROM, 0 = load RAM.
- ld_addr  in  ROM_AW  backdoor index; RAM uses bits [10:0].
- ld_data  in  8  backdoor data.
- txn_valid  out  1  FIFO head valid.
- txn_ready  in  1  consumer pop.
- txn_addr  out  16  logged address.
- txn_data  out  8  logged data.
- txn_write  out  1  1 = write cycle.
- txn_overflow  out  1  sticky; a transaction was dropped.

Behaviour:
- Edge detection:
  - syn_q is a registered copy of syn_clk; reset value is 1, so a high syn_clk at reset release is not taken as a rise.
  - rise = syn_clk & ~syn_q; fall = ~syn_clk & syn_q.
- Decode:
  - RAM when addr < $2000; index = addr[10:0] (mirrored every $800).
  - ROM when addr >= $8000; index = addr[ROM_AW-1:0].
  - Anything else is unmapped.
- Read cycle (rise with ren=1):
  - Latch addr on the rise clock.
  - cpu_data_in is updated on the next clk (1-clk latency) with mem[index], or the open-bus latch if unmapped.
  - cpu_data_in holds until the next read.
  - The open-bus latch takes the read value.
  - Push txn {addr, data, write=0} on the same clk cpu_data_in updates.
- Write cycle (rise with wen=1):
  - Latch addr on the rise; sample cpu_data_out on the fall clock.
  - Commit on the fall clock: RAM is written; ROM and unmapped writes are ignored.
  - The open-bus latch takes the write data in all cases.
  - Push txn {addr, data, write=1} on the fall clock.
- Rise with ren=wen=0: no cycle, no push.
- Fall without a latched write: no action.
- Backdoor load:
  - ld_ready = ~(fall & latched write), i.e. a CPU write commit wins arbitration.
  - A load completes on the clk where ld_valid & ld_ready are both high.
  - A load to RAM visible to a read launched 1 clk later.
- FIFO:
  - Push when not full; when full, drop the entry and set txn_overflow (cleared only by rst).
  - Pop on txn_valid & txn_ready.
  - Simultaneous push/pop when full: pop then push, no drop.
  - Simultaneous push/pop when empty: entry appears at the head next clk.
  - Pointers wrap modulo FIFO_DEPTH; a count register (clog2(FIFO_DEPTH)+1 bits) distinguishes full from empty.
- Reset values:
  - cpu_data_in = 8'h00, txn_valid = 0, txn_overflow = 0.
  - FIFO emptied, open-bus latch = OPEN_BUS_INIT.
  - txn_addr/txn_data/txn_write = 0.
  - Memory arrays are not reset.
- Reset mid-cycle: any latched, uncommitted write is discarded; memory keeps its prior contents.

Test Plan:
- Backdoor load ROM $7FFC=$00, $7FFD=$80 (ROM_AW=15); release rst; CPU fetches $FFFC/$FFFD -> cpu_data_in $00 then $80, 1 clk after each phi2 rise; two read txns logged.
- CPU writes $5A to $0012, then reads $0812, $1012, $1812 -> each read returns $5A; txn log holds {0012,5A,1} followed by 3 read entries.
- CPU writes $33 to $8000, then reads $8000 (ROM preloaded $EA) -> $EA; read of unmapped $4020 returns $33 (open bus).
- Hold txn_ready=0, run 17 read cycles (FIFO_DEPTH=16) -> txn_valid=1, count 16, txn_overflow=1; draining yields the first 16 addresses in order.
- ld_valid asserted on the same clk as a CPU write fall to RAM $0005 ($11 vs ld $22 at $005) -> ld_ready=0 that clk; load lands next clk; final read $0005 = $22.
- Assert rst while syn_clk high between rise and fall of a write to $0001 (prior $00) -> outputs at reset values; subsequent read of $0001 returns $00.
